// File: rtl/datapath_if.sv
// Controller <-> datapath bus: instruction fields and operands in, status and result out.
interface datapath_if #(
  parameter int width = 8
);
  logic [width-1:0] N_IN;
  logic [2:0]       opcode;
  logic [1:0]       operand1;
  logic [1:0]       operand2;
  logic             DONE;
  logic             ZERO_FLAG;
  logic [width-1:0] RESULT;
  logic             RESULT_VALID;
  logic             OVERFLOW;

  modport master (
    output N_IN, opcode, operand1, operand2, DONE,
    input  ZERO_FLAG, RESULT, RESULT_VALID, OVERFLOW
  );

  modport slave (
    input  N_IN, opcode, operand1, operand2, DONE,
    output ZERO_FLAG, RESULT, RESULT_VALID, OVERFLOW
  );
endinterface

// File: rtl/datapath.sv
// Four-register datapath executing 3-bit controller instructions, with zero test,
// sticky ADD overflow and a one-shot result capture of R1 on DONE.
module datapath #(
  parameter int width = 8
) (
  input  logic       CLK,
  input  logic       RST,
  datapath_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LDI1  = 3'b001,
    OP_RSVD  = 3'b010,
    OP_DEC   = 3'b011,
    OP_LOADN = 3'b100,
    OP_TEST  = 3'b101,
    OP_ADD   = 3'b110,
    OP_MOV   = 3'b111
  } op_e;

  op_e              op;
  logic [width-1:0] regs [4];
  logic [width-1:0] rd1;
  logic [width-1:0] rd2;
  logic [width-1:0] wr_data;
  logic             wr_en;
  logic [width:0]   sum;
  logic             zf_q;
  logic             ovf_q;
  logic             valid_q;
  logic [width-1:0] result_q;

  // Unsigned add with the carry-out kept as the extra top bit.
  function automatic logic [width:0] add_carry(input logic [width-1:0] a,
                                               input logic [width-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign op  = op_e'(bus.opcode);
  assign rd1 = regs[bus.operand1];
  assign rd2 = regs[bus.operand2];
  assign sum = add_carry(rd1, rd2);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = rd1;
    unique case (op)
      OP_LDI1:  begin wr_en = 1'b1; wr_data = {{(width-1){1'b0}}, 1'b1}; end
      OP_DEC:   begin wr_en = 1'b1; wr_data = rd1 - {{(width-1){1'b0}}, 1'b1}; end
      OP_LOADN: begin wr_en = 1'b1; wr_data = bus.N_IN; end
      OP_ADD:   begin wr_en = 1'b1; wr_data = sum[width-1:0]; end
      OP_MOV:   begin wr_en = 1'b1; wr_data = rd2; end
      OP_NOP, OP_RSVD, OP_TEST: begin wr_en = 1'b0; wr_data = rd1; end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      zf_q     <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (wr_en) regs[bus.operand1] <= wr_data;
      if (op == OP_TEST) zf_q <= (rd1 == '0);
      if (op == OP_LOADN)     ovf_q <= 1'b0;
      else if (op == OP_ADD)  ovf_q <= ovf_q | sum[width];
      // Capture sees pre-edge R1; a LOADN on the same edge re-arms capture.
      if (bus.DONE && !valid_q) begin
        result_q <= regs[1];
        valid_q  <= 1'b1;
      end
      if (op == OP_LOADN) valid_q <= 1'b0;
    end
  end

  assign bus.ZERO_FLAG    = (op == OP_TEST) ? (rd1 == '0) : zf_q;
  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = valid_q;
  assign bus.OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed controller programs plus random
// instruction streams against a behavioural model of the register machine.
module tb_datapath;

  localparam logic [2:0] NOP = 3'b000, LDI1 = 3'b001, RSVD = 3'b010, DEC = 3'b011,
                         LOADN = 3'b100, TEST = 3'b101, ADD = 3'b110, MOV = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  datapath_if #(.width(8)) bus ();

  datapath #(.width(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int   m_r [4];
  bit   m_zf;
  int   m_res;
  bit   m_valid;
  bit   m_ovf;
  logic zf_act;
  logic zf_exp;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_zf = 0; m_res = 0; m_valid = 0; m_ovf = 0;
  endtask

  // Present one instruction for a full cycle; sample the combinational flag mid-cycle.
  task automatic exec(input logic [2:0] op, input int a, input int b,
                      input int n, input bit d);
    int s;
    int r1_pre;
    @(negedge clk);
    bus.opcode   = op;
    bus.operand1 = 2'(a);
    bus.operand2 = 2'(b);
    bus.N_IN     = 8'(n);
    bus.DONE     = d;
    #1;
    zf_act = bus.ZERO_FLAG;
    zf_exp = (op == TEST) ? (m_r[a] == 0) : m_zf;
    @(posedge clk);
    r1_pre = m_r[1];
    case (op)
      LDI1:  m_r[a] = 1;
      DEC:   m_r[a] = (m_r[a] + 255) % 256;
      LOADN: begin m_r[a] = n % 256; m_ovf = 0; end
      TEST:  m_zf = (m_r[a] == 0);
      ADD:   begin s = m_r[a] + m_r[b]; if (s > 255) m_ovf = 1; m_r[a] = s % 256; end
      MOV:   m_r[a] = m_r[b];
      default: ;
    endcase
    if (d && !m_valid) begin m_res = r1_pre; m_valid = 1; end
    if (op == LOADN) m_valid = 0;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.opcode = NOP; bus.DONE = 1'b0;
  endtask

  task automatic test_reset();
    bus.opcode = NOP; bus.operand1 = 0; bus.operand2 = 0; bus.N_IN = 0; bus.DONE = 0;
    rst = 1'b1;
    m_reset();
    #12;
    total++; if (bus.ZERO_FLAG !== 1'b0) begin bad++; $display("FAIL reset_zf got=%b exp=0", bus.ZERO_FLAG); end
    total++; if (bus.RESULT !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", bus.RESULT); end
    total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.RESULT_VALID); end
    total++; if (bus.OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.OVERFLOW); end
    // Instructions and DONE are ignored while reset is held
    @(negedge clk); bus.opcode = LDI1; bus.operand1 = 1; bus.DONE = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.RESULT_VALID !== 1'b0) begin bad++; $display("FAIL reset_ignore_done got=%b exp=0", bus.RESULT_VALID); end
    bus.opcode = TEST; bus.operand1 = 1; bus.DONE = 1'b0; #1;
    total++; if (bus.ZERO_FLAG !== 1'b1) begin bad++; $display("FAIL reset_test_zf got=%b exp=1", bus.ZERO_FLAG); end
    bus.opcode = NOP;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fib(input int n, input int exp_res, input bit exp_ovf);
    exec(LOADN, 0, 0, n, 0);
    exec(LDI1, 1, 0, 0, 0);
    exec(LDI1, 2, 0, 0, 0);
    for (int it = 1; it <= n; it++) begin
      exec(MOV, 3, 1, 0, 0);
      exec(ADD, 1, 2, 0, 0);
      exec(MOV, 2, 3, 0, 0);
      exec(DEC, 0, 0, 0, 0);
      exec(TEST, 0, 0, 0, 0);
      total++;
      if (zf_act !== zf_exp || zf_act !== (it == n))
        begin bad++; $display("FAIL fib%0d_zf_iter%0d got=%b exp=%b", n, it, zf_act, (it == n)); end
    end
    exec(NOP, 0, 0, 0, 1);
    idle();
    total++; if (bus.RESULT !== 8'(exp_res) || bus.RESULT !== 8'(m_res))
      begin bad++; $display("FAIL fib%0d_result got=%0d exp=%0d", n, bus.RESULT, exp_res); end
    total++; if (bus.RESULT_VALID !== 1'b1) begin bad++; $display("FAIL fib%0d_valid got=%b exp=1", n, bus.RESULT_VALID); end
    total++; if (bus.OVERFLOW !== exp_ovf) begin bad++; $display("FAIL fib%0d_ovf got=%b exp=%b", n, bus.OVERFLOW, exp_ovf); end
  endtask

  task automatic test_boundary();
    exec(LOADN, 0, 0, 0, 0);
    exec(TEST, 0, 0, 0, 0);
    total++; if (zf_act !== 1'b1) begin bad++; $display("FAIL zero_n_test got=%b exp=1", zf_act); end
    exec(DEC, 0, 0, 0, 0);
    exec(TEST, 0, 0, 0, 0);
    total++; if (zf_act !== 1'b0) begin bad++; $display("FAIL wrap_test got=%b exp=0", zf_act); end
    exec(NOP, 0, 0, 0, 0);
    total++; if (zf_act !== 1'b0) begin bad++; $display("FAIL zf_hold got=%b exp=0", zf_act); end
    exec(MOV, 1, 0, 0, 0);
    exec(NOP, 0, 0, 0, 1);
    idle();
    total++; if (bus.RESULT !== 8'd255) begin bad++; $display("FAIL dec_wrap got=%0d exp=255", bus.RESULT); end
    total++; if (bus.OVERFLOW !== 1'b0) begin bad++; $display("FAIL dec_no_ovf got=%b exp=0", bus.OVERFLOW); end
    // Self-add doubles; self-move is a no-op
    exec(LOADN, 3, 0, 7, 0);
    exec(LDI1, 1, 0, 0, 0);
    exec(ADD, 1, 1, 0, 0);
    exec(ADD, 1, 1, 0, 0);
    exec(ADD, 1, 1, 0, 0);
    exec(MOV, 1, 1, 0, 0);
    exec(RSVD, 1, 0, 0, 1);
    idle();
    total++; if (bus.RESULT !== 8'd8) begin bad++; $display("FAIL self_add got=%0d exp=8", bus.RESULT); end
  endtask

  task automatic test_async_reset();
    exec(LOADN, 0, 0, 5, 0);
    exec(LDI1, 1, 0, 0, 0);
    exec(LDI1, 2, 0, 0, 0);
    for (int it = 0; it < 2; it++) begin
      exec(MOV, 3, 1, 0, 0); exec(ADD, 1, 2, 0, 0); exec(MOV, 2, 3, 0, 0);
      exec(DEC, 0, 0, 0, 0); exec(TEST, 0, 0, 0, 0);
    end
    exec(MOV, 3, 1, 0, 0);
    exec(ADD, 1, 2, 0, 0);
    @(negedge clk); bus.opcode = MOV; bus.operand1 = 2; bus.operand2 = 3; bus.DONE = 1'b1;
    #2; rst = 1'b1; m_reset(); #1;
    total++; if (bus.RESULT !== 8'd0 || bus.RESULT_VALID !== 1'b0 || bus.OVERFLOW !== 1'b0)
      begin bad++; $display("FAIL async_rst_outputs got=%0d/%b/%b exp=0/0/0", bus.RESULT, bus.RESULT_VALID, bus.OVERFLOW); end
    bus.opcode = TEST; bus.operand1 = 1; #1;
    total++; if (bus.ZERO_FLAG !== 1'b1) begin bad++; $display("FAIL async_rst_r1 got=%b exp=1", bus.ZERO_FLAG); end
    bus.opcode = NOP; bus.DONE = 1'b0;
    #13; rst = 1'b0;
    test_fib(5, 13, 0);
  endtask

  task automatic test_done_hold();
    exec(LOADN, 0, 0, 3, 0);
    exec(LDI1, 1, 0, 0, 0);
    exec(LDI1, 2, 0, 0, 0);
    exec(ADD, 1, 2, 0, 1);
    exec(ADD, 1, 2, 0, 1);
    exec(ADD, 1, 2, 0, 1);
    idle();
    total++; if (bus.RESULT !== 8'd1 || bus.RESULT_VALID !== 1'b1)
      begin bad++; $display("FAIL done_hold got=%0d/%b exp=1/1", bus.RESULT, bus.RESULT_VALID); end
    exec(LOADN, 3, 0, 9, 0);
    idle();
    total++; if (bus.RESULT !== 8'd1 || bus.RESULT_VALID !== 1'b0)
      begin bad++; $display("FAIL loadn_clear got=%0d/%b exp=1/0", bus.RESULT, bus.RESULT_VALID); end
    exec(NOP, 0, 0, 0, 1);
    idle();
    total++; if (bus.RESULT !== 8'd4 || bus.RESULT_VALID !== 1'b1)
      begin bad++; $display("FAIL recapture got=%0d/%b exp=4/1", bus.RESULT, bus.RESULT_VALID); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      exec(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      total++; if (zf_act !== zf_exp) begin bad++; $display("FAIL rnd%0d_zf got=%b exp=%b", i, zf_act, zf_exp); end
      total++; if (bus.RESULT !== 8'(m_res)) begin bad++; $display("FAIL rnd%0d_result got=%0d exp=%0d", i, bus.RESULT, m_res); end
      total++; if (bus.RESULT_VALID !== m_valid) begin bad++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, bus.RESULT_VALID, m_valid); end
      total++; if (bus.OVERFLOW !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, bus.OVERFLOW, m_ovf); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fib(5, 13, 0);
    test_fib(11, 233, 0);
    test_fib(12, 121, 1);
    test_boundary();
    test_async_reset();
    test_done_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
